// File: rtl/mux_n_reg.sv
// N-channel W-bit multiplexer with direct or round-robin selection, feeding a
// one-entry registered output stage. Define MUX_N_REG_CNT_EN to build xfer_cnt.
module mux_n_reg #(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    xfer_cnt
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic          has_grant;
  logic          ld;
  logic          xfer;
  logic [W-1:0]  sel_data;

  // The output register can take a word when empty or when drained this cycle.
  assign ld = !out_valid || out_ready;

  // NOTE: every variable written in always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    has_grant = 1'b0;
    g         = '0;
    if (!mode) begin
      if (in_valid[s]) begin
        has_grant = 1'b1;
        g         = s;
      end
    end else begin
      // Scan ptr, ptr+1, ... ; SW-bit addition wraps modulo N.
      for (int i = 0; i < N; i++) begin
        if (!has_grant && in_valid[ptr + SW'(i)]) begin
          has_grant = 1'b1;
          g         = ptr + SW'(i);
        end
      end
    end
  end

  // Nothing is accepted while reset is asserted.
  assign xfer = has_grant && ld && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;
  end

  assign sel_data = in_data[g*W +: W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= sel_data;
      out_ch    <= g;
      out_valid <= 1'b1;
      if (mode) ptr <= g + SW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_N_REG_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Self-checking bench for mux_n_reg: table-driven grant vectors plus a
// scoreboard queue of words expected at the registered output.
module tb_mux_n_reg;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  s;
  logic           mode;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    xfer_cnt;

  logic [W-1:0] chan_data [N];

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] ch;
  } exp_t;

  typedef struct {
    logic [N-1:0]  v;
    logic          mode;
    logic [SW-1:0] s;
    logic          ordy;
    logic [N-1:0]  rdy;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic        m_ovalid;
  logic [15:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) in_data[k*W +: W] = chan_data[k];
  end

  mux_n_reg #(.W(W), .N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .mode      (mode),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef MUX_N_REG_CNT_EN
    return m_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // Hold reset for the given number of cycles; called just after a negedge or at t=0.
  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    in_valid  = 8'hFF;
    mode      = 1'b1;
    s         = 3'd0;
    out_ready = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      #1;
      check("rst_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_ch", 32'(out_ch), 32'h0);
      check("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
      @(negedge clk);
    end
    rst      = 1'b0;
    m_ovalid = 1'b0;
    m_cnt    = 16'h0;
    sb.delete();
  endtask

  // One cycle: drive, check in_ready against the hand-derived value, update the
  // scoreboard at the edge, then check the registered outputs.
  task automatic step(input logic [N-1:0] v, input logic md, input logic [SW-1:0] sel,
                      input logic ordy, input logic [N-1:0] exp_rdy);
    exp_t e;
    in_valid  = v;
    mode      = md;
    s         = sel;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_ovalid && ordy) begin
      if (sb.size() > 0) void'(sb.pop_front());
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    if (exp_rdy != '0) begin
      for (int k = 0; k < N; k++) begin
        if (exp_rdy[k]) begin
          e.data = chan_data[k];
          e.ch   = SW'(k);
        end
      end
      sb.push_back(e);
      m_ovalid = 1'b1;
    end else if (ordy) begin
      m_ovalid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ovalid));
    if (m_ovalid) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'(sb.size()), 32'h1);
      end else begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
        check("out_ch", 32'(out_ch), 32'(sb[0].ch));
      end
    end
    check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt()));
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N; k++) chan_data[k] = 16'h1000 + 16'(k);
    chan_data[5] = 16'hA5A5;

    // Direct mode, then a select whose channel is idle drains the register.
    vecs.push_back('{8'h20, 1'b0, 3'd5, 1'b1, 8'h20});
    vecs.push_back('{8'h20, 1'b0, 3'd2, 1'b1, 8'h00});
    vecs.push_back('{8'hFB, 1'b0, 3'd2, 1'b1, 8'h00});
    // Round-robin fairness from ptr=0: one grant per cycle, 0..7 then 0.
    for (int k = 0; k <= N; k++) vecs.push_back('{8'hFF, 1'b1, 3'd0, 1'b1, 8'(1 << (k % N))});
    // Skip and wrap: grant ch5 puts ptr at 6, then 0,2 alternate with wrap.
    vecs.push_back('{8'h20, 1'b1, 3'd0, 1'b1, 8'h20});
    vecs.push_back('{8'h05, 1'b1, 3'd0, 1'b1, 8'h01});
    vecs.push_back('{8'h05, 1'b1, 3'd0, 1'b1, 8'h04});
    vecs.push_back('{8'h05, 1'b1, 3'd0, 1'b1, 8'h01});
    vecs.push_back('{8'h00, 1'b1, 3'd0, 1'b1, 8'h00});

    do_reset(2);

    foreach (vecs[i]) step(vecs[i].v, vecs[i].mode, vecs[i].s, vecs[i].ordy, vecs[i].rdy);
    // ch5 data restored so the fairness sweep after chan_data edits stays distinct
    chan_data[5] = 16'h1005;

    // Backpressure: hold 16'h1234 from ch3 for 4 cycles, mode flip must not disturb it.
    chan_data[3] = 16'h1234;
    step(8'h08, 1'b0, 3'd3, 1'b1, 8'h08);
    step(8'hFF, 1'b0, 3'd3, 1'b0, 8'h00);
    step(8'hFF, 1'b1, 3'd3, 1'b0, 8'h00);
    step(8'hFF, 1'b0, 3'd6, 1'b0, 8'h00);
    step(8'hFF, 1'b0, 3'd3, 1'b0, 8'h00);
    check("bp_out_data", 32'(out_data), 32'h1234);
    check("bp_out_ch", 32'(out_ch), 32'd3);
    // Drain and new load in the same cycle.
    step(8'hFF, 1'b0, 3'd4, 1'b1, 8'h10);
    check("bp_reload_data", 32'(out_data), 32'h1004);

    // Reset while holding a word discards it without a handshake.
    step(8'h01, 1'b0, 3'd0, 1'b0, 8'h00);
    do_reset(1);

    // 21 full-rate cycles: first loads, the next 20 drain => 20 handshakes.
    // ptr is 0 after reset so grants go 0,1,...
    for (int k = 0; k < 21; k++) step(8'hFF, 1'b1, 3'd0, 1'b1, 8'(1 << (k % N)));
`ifdef MUX_N_REG_CNT_EN
    check("cnt_20", 32'(xfer_cnt), 32'd20);
    dut.cnt_q = 16'hFFFE;
    m_cnt     = 16'hFFFE;
    for (int k = 21; k < 24; k++) step(8'hFF, 1'b1, 3'd0, 1'b1, 8'(1 << (k % N)));
    check("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
`else
    check("cnt_off", 32'(xfer_cnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
